alu_rs: RTL and testbench

ALU reservation station, directly upstream of the ALU. Buffers up to `RS_SIZE` issued integer/branch/jump µops, wakes their operands from the two result broadcast buses (ALU and LSB), and sends at most one fully-ready µop per cycle to the ALU through registered outputs. The ALU's own result bus is fed back as a wakeup source.

---
 rtl/alu_rs_pkg.sv | 42 ++++
 rtl/alu_rs_if.sv | 48 ++++
 rtl/alu_rs_prio_enc.sv | 21 ++
 rtl/alu_rs.sv | 154 +++++++++++++++
 tb/tb_alu_rs.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: operand/address/tag types, op enum
// and RS sizing constants.
package alu_rs_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned ROB_WIDTH = 4;
  localparam int unsigned RS_SIZE   = 16;
  localparam int unsigned RS_WIDTH  = 4;

  typedef logic [31:0]          DATA_TYPE;
  typedef logic [31:0]          ADDR_TYPE;
  typedef logic [ROB_WIDTH-1:0] ROB_INDEX_TYPE;
  typedef logic [RS_WIDTH-1:0]  RS_INDEX_TYPE;

  typedef enum logic [4:0] {
    OPENUM_NOP,
    OPENUM_ADD,
    OPENUM_SUB,
    OPENUM_ADDI,
    OPENUM_AND,
    OPENUM_OR,
    OPENUM_XOR,
    OPENUM_SLL,
    OPENUM_SRL,
    OPENUM_SLT,
    OPENUM_BEQ,
    OPENUM_BNE,
    OPENUM_JAL,
    OPENUM_JALR,
    OPENUM_LUI,
    OPENUM_AUIPC
  } OPENUM_TYPE;

  // True when a broadcast bus carries the tag an operand is waiting on.
  function automatic logic tag_hit(input logic bus_valid, input ROB_INDEX_TYPE bus_tag,
                                   input ROB_INDEX_TYPE want);
    return bus_valid && (bus_tag == want);
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Issue, result-broadcast and ALU-dispatch signals of the ALU reservation station.
interface alu_rs_if;
  import alu_rs_pkg::*;

  logic          issue_valid;
  OPENUM_TYPE    issue_op;
  DATA_TYPE      issue_vj;
  DATA_TYPE      issue_vk;
  logic          issue_has_qj;
  logic          issue_has_qk;
  ROB_INDEX_TYPE issue_qj;
  ROB_INDEX_TYPE issue_qk;
  ROB_INDEX_TYPE issue_rob_index;
  ADDR_TYPE      issue_pc;
  DATA_TYPE      issue_imm;

  logic          alu_ready;
  ROB_INDEX_TYPE alu_rob_index;
  DATA_TYPE      alu_result;
  logic          lsb_ready;
  ROB_INDEX_TYPE lsb_rob_index;
  DATA_TYPE      lsb_result;

  logic          rs_full;
  logic          rs_to_alu_ready;
  OPENUM_TYPE    rs_to_alu_op;
  DATA_TYPE      rs_to_alu_rs1;
  DATA_TYPE      rs_to_alu_rs2;
  ROB_INDEX_TYPE rs_to_alu_rob_index;
  ADDR_TYPE      rs_to_alu_PC;
  DATA_TYPE      rs_to_alu_imm;

  modport master (
    output issue_valid, issue_op, issue_vj, issue_vk, issue_has_qj, issue_has_qk,
           issue_qj, issue_qk, issue_rob_index, issue_pc, issue_imm,
           alu_ready, alu_rob_index, alu_result, lsb_ready, lsb_rob_index, lsb_result,
    input  rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
           rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm
  );

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_vk, issue_has_qj, issue_has_qk,
           issue_qj, issue_qk, issue_rob_index, issue_pc, issue_imm,
           alu_ready, alu_rob_index, alu_result, lsb_ready, lsb_rob_index, lsb_result,
    output rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
           rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm
  );
endinterface

// File: rtl/alu_rs_prio_enc.sv
// Lowest-set-bit priority encoder: reports whether any request is set and the index
// of the lowest one.
module rs_prio_enc #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued uops, wakes operands from the ALU/LSB
// broadcast buses and dispatches the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int unsigned RS_SIZE  = alu_rs_pkg::RS_SIZE,
  parameter int unsigned RS_WIDTH = alu_rs_pkg::RS_WIDTH
) (
  input logic     clk_in,
  input logic     rst_in,
  input logic     rdy_in,
  input logic     clr_in,
  alu_rs_if.slave bus
);
  import alu_rs_pkg::*;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] has_qj;
  logic [RS_SIZE-1:0] has_qk;
  OPENUM_TYPE         op_q  [RS_SIZE];
  DATA_TYPE           vj    [RS_SIZE];
  DATA_TYPE           vk    [RS_SIZE];
  ROB_INDEX_TYPE      qj    [RS_SIZE];
  ROB_INDEX_TYPE      qk    [RS_SIZE];
  ROB_INDEX_TYPE      rob_q [RS_SIZE];
  ADDR_TYPE           pc_q  [RS_SIZE];
  DATA_TYPE           imm_q [RS_SIZE];

  logic [RS_SIZE-1:0]  free_vec;
  logic [RS_SIZE-1:0]  ready_vec;
  logic                free_found;
  logic                sel_found;
  logic [RS_WIDTH-1:0] free_idx;
  logic [RS_WIDTH-1:0] sel_idx;

  always_comb begin
    free_vec  = ~busy;
    ready_vec = busy & ~has_qj & ~has_qk;
  end

  assign bus.rs_full = &busy;

  rs_prio_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_free_enc (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_sel_enc (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy                    <= '0;
      has_qj                  <= '0;
      has_qk                  <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= OPENUM_NOP;
        vj[i]    <= '0;
        vk[i]    <= '0;
        qj[i]    <= '0;
        qk[i]    <= '0;
        rob_q[i] <= '0;
        pc_q[i]  <= '0;
        imm_q[i] <= '0;
      end
      bus.rs_to_alu_ready     <= FALSE;
      bus.rs_to_alu_op        <= OPENUM_NOP;
      bus.rs_to_alu_rs1       <= '0;
      bus.rs_to_alu_rs2       <= '0;
      bus.rs_to_alu_rob_index <= '0;
      bus.rs_to_alu_PC        <= '0;
      bus.rs_to_alu_imm       <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        busy                <= '0;
        bus.rs_to_alu_ready <= FALSE;
      end else begin
        // Wakeup only touches waiting entries, so it never overlaps the free slot
        // written by issue nor the ready entry taken by dispatch.
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && has_qj[i]) begin
            if (tag_hit(bus.alu_ready, bus.alu_rob_index, qj[i])) begin
              vj[i]     <= bus.alu_result;
              has_qj[i] <= FALSE;
            end else if (tag_hit(bus.lsb_ready, bus.lsb_rob_index, qj[i])) begin
              vj[i]     <= bus.lsb_result;
              has_qj[i] <= FALSE;
            end
          end
          if (busy[i] && has_qk[i]) begin
            if (tag_hit(bus.alu_ready, bus.alu_rob_index, qk[i])) begin
              vk[i]     <= bus.alu_result;
              has_qk[i] <= FALSE;
            end else if (tag_hit(bus.lsb_ready, bus.lsb_rob_index, qk[i])) begin
              vk[i]     <= bus.lsb_result;
              has_qk[i] <= FALSE;
            end
          end
        end

        bus.rs_to_alu_ready <= sel_found;
        if (sel_found) begin
          bus.rs_to_alu_op        <= op_q[sel_idx];
          bus.rs_to_alu_rs1       <= vj[sel_idx];
          bus.rs_to_alu_rs2       <= vk[sel_idx];
          bus.rs_to_alu_rob_index <= rob_q[sel_idx];
          bus.rs_to_alu_PC        <= pc_q[sel_idx];
          bus.rs_to_alu_imm       <= imm_q[sel_idx];
          busy[sel_idx]           <= FALSE;
        end

        if (bus.issue_valid && free_found) begin
          busy[free_idx]  <= TRUE;
          op_q[free_idx]  <= bus.issue_op;
          rob_q[free_idx] <= bus.issue_rob_index;
          pc_q[free_idx]  <= bus.issue_pc;
          imm_q[free_idx] <= bus.issue_imm;
          qj[free_idx]    <= bus.issue_qj;
          qk[free_idx]    <= bus.issue_qk;

          if (!bus.issue_has_qj) begin
            vj[free_idx]     <= bus.issue_vj;
            has_qj[free_idx] <= FALSE;
          end else if (tag_hit(bus.alu_ready, bus.alu_rob_index, bus.issue_qj)) begin
            vj[free_idx]     <= bus.alu_result;
            has_qj[free_idx] <= FALSE;
          end else if (tag_hit(bus.lsb_ready, bus.lsb_rob_index, bus.issue_qj)) begin
            vj[free_idx]     <= bus.lsb_result;
            has_qj[free_idx] <= FALSE;
          end else begin
            vj[free_idx]     <= bus.issue_vj;
            has_qj[free_idx] <= TRUE;
          end

          if (!bus.issue_has_qk) begin
            vk[free_idx]     <= bus.issue_vk;
            has_qk[free_idx] <= FALSE;
          end else if (tag_hit(bus.alu_ready, bus.alu_rob_index, bus.issue_qk)) begin
            vk[free_idx]     <= bus.alu_result;
            has_qk[free_idx] <= FALSE;
          end else if (tag_hit(bus.lsb_ready, bus.lsb_rob_index, bus.issue_qk)) begin
            vk[free_idx]     <= bus.lsb_result;
            has_qk[free_idx] <= FALSE;
          end else begin
            vk[free_idx]     <= bus.issue_vk;
            has_qk[free_idx] <= TRUE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: table of single-uop issue/wakeup/dispatch cases plus
// hand-written full, flush, stall and reset sequences.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk;
  logic rst_n;
  logic rdy;
  logic clr;
  int   n_checks;
  int   n_fail;

  alu_rs_if bus ();

  alu_rs #(.RS_SIZE(16), .RS_WIDTH(4)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .clr_in (clr),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bsel: 0 none, 1 ALU bus same cycle as issue, 2 LSB bus same cycle, 3 ALU bus next cycle
  typedef struct {
    OPENUM_TYPE  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic        hqj;
    logic [3:0]  qj;
    logic        hqk;
    logic [3:0]  qk;
    logic [3:0]  rob;
    logic [31:0] pc;
    logic [31:0] imm;
    int          bsel;
    logic [3:0]  btag;
    logic [31:0] bval;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid     = 1'b0;
    bus.issue_op        = OPENUM_NOP;
    bus.issue_vj        = '0;
    bus.issue_vk        = '0;
    bus.issue_has_qj    = 1'b0;
    bus.issue_has_qk    = 1'b0;
    bus.issue_qj        = '0;
    bus.issue_qk        = '0;
    bus.issue_rob_index = '0;
    bus.issue_pc        = '0;
    bus.issue_imm       = '0;
    bus.alu_ready       = 1'b0;
    bus.alu_rob_index   = '0;
    bus.alu_result      = '0;
    bus.lsb_ready       = 1'b0;
    bus.lsb_rob_index   = '0;
    bus.lsb_result      = '0;
  endtask

  task automatic drive_issue(input OPENUM_TYPE op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic hqj, input logic [3:0] qj, input logic hqk,
                             input logic [3:0] qk, input logic [3:0] rob,
                             input logic [31:0] pc, input logic [31:0] imm);
    bus.issue_valid     = 1'b1;
    bus.issue_op        = op;
    bus.issue_vj        = vj;
    bus.issue_vk        = vk;
    bus.issue_has_qj    = hqj;
    bus.issue_qj        = qj;
    bus.issue_has_qk    = hqk;
    bus.issue_qk        = qk;
    bus.issue_rob_index = rob;
    bus.issue_pc        = pc;
    bus.issue_imm       = imm;
  endtask

  task automatic alu_bcast(input logic [3:0] tag, input logic [31:0] val);
    bus.alu_ready     = 1'b1;
    bus.alu_rob_index = tag;
    bus.alu_result    = val;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rdy      = 1'b1;
    clr      = 1'b0;
    idle_inputs();

    tbl[0] = '{OPENUM_ADD,  32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 32'h100, 32'd0,
               0, 4'd0, 32'd0, 32'd5, 32'd7};
    tbl[1] = '{OPENUM_ADDI, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd1, 32'h104, 32'd10,
               3, 4'd2, 32'h20, 32'h20, 32'd0};
    tbl[2] = '{OPENUM_SUB,  32'h0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd5, 32'h108, 32'd0,
               2, 4'd6, 32'hDEAD, 32'hDEAD, 32'd1};
    tbl[3] = '{OPENUM_AND,  32'h100, 32'h999, 1'b0, 4'd0, 1'b1, 4'd7, 4'd8, 32'h10C, 32'd0,
               1, 4'd7, 32'h55, 32'h100, 32'h55};
    tbl[4] = '{OPENUM_OR,   32'h1, 32'h2, 1'b1, 4'd8, 1'b1, 4'd8, 4'd11, 32'h110, 32'd0,
               3, 4'd8, 32'h77, 32'h77, 32'h77};
    tbl[5] = '{OPENUM_BEQ,  32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12, 32'h1000, 32'hFFFFFFFC,
               0, 4'd0, 32'd0, 32'd9, 32'd9};

    tick();
    tick();
    chk("reset ready", 32'(bus.rs_to_alu_ready), 32'd0);
    chk("reset rs1", bus.rs_to_alu_rs1, 32'd0);
    chk("reset rob", 32'(bus.rs_to_alu_rob_index), 32'd0);
    chk("reset full", 32'(bus.rs_full), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    for (int r = 0; r < 6; r++) begin
      drive_issue(tbl[r].op, tbl[r].vj, tbl[r].vk, tbl[r].hqj, tbl[r].qj, tbl[r].hqk,
                  tbl[r].qk, tbl[r].rob, tbl[r].pc, tbl[r].imm);
      if (tbl[r].bsel == 1) alu_bcast(tbl[r].btag, tbl[r].bval);
      if (tbl[r].bsel == 2) begin
        bus.lsb_ready     = 1'b1;
        bus.lsb_rob_index = tbl[r].btag;
        bus.lsb_result    = tbl[r].bval;
      end
      tick();
      idle_inputs();
      if (tbl[r].bsel == 3) begin
        chk($sformatf("row%0d wait", r), 32'(bus.rs_to_alu_ready), 32'd0);
        alu_bcast(tbl[r].btag, tbl[r].bval);
        tick();
        idle_inputs();
      end
      chk($sformatf("row%0d pre", r), 32'(bus.rs_to_alu_ready), 32'd0);
      tick();
      chk($sformatf("row%0d ready", r), 32'(bus.rs_to_alu_ready), 32'd1);
      chk($sformatf("row%0d op", r), 32'(bus.rs_to_alu_op), 32'(tbl[r].op));
      chk($sformatf("row%0d rs1", r), bus.rs_to_alu_rs1, tbl[r].e_rs1);
      chk($sformatf("row%0d rs2", r), bus.rs_to_alu_rs2, tbl[r].e_rs2);
      chk($sformatf("row%0d rob", r), 32'(bus.rs_to_alu_rob_index), 32'(tbl[r].rob));
      chk($sformatf("row%0d pc", r), bus.rs_to_alu_PC, tbl[r].pc);
      chk($sformatf("row%0d imm", r), bus.rs_to_alu_imm, tbl[r].imm);
      tick();
      chk($sformatf("row%0d done", r), 32'(bus.rs_to_alu_ready), 32'd0);
      chk($sformatf("row%0d hold", r), bus.rs_to_alu_rs1, tbl[r].e_rs1);
    end

    // Fill all entries waiting on tag 9.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("full before last", 32'(bus.rs_full), 32'd0);
      drive_issue(OPENUM_ADD, 32'h0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i), 32'h0, 32'h0);
      tick();
    end
    idle_inputs();
    chk("full set", 32'(bus.rs_full), 32'd1);
    drive_issue(OPENUM_ADD, 32'hBAD, 32'hBAD, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14, 32'h0, 32'h0);
    tick();
    idle_inputs();
    chk("full after 17th", 32'(bus.rs_full), 32'd1);
    chk("17th no dispatch", 32'(bus.rs_to_alu_ready), 32'd0);
    alu_bcast(4'd9, 32'h900);
    tick();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("drain%0d ready", i), 32'(bus.rs_to_alu_ready), 32'd1);
      chk($sformatf("drain%0d rob", i), 32'(bus.rs_to_alu_rob_index), 32'(i));
      chk($sformatf("drain%0d rs1", i), bus.rs_to_alu_rs1, 32'h900);
      chk($sformatf("drain%0d rs2", i), bus.rs_to_alu_rs2, 32'(i));
    end
    tick();
    chk("drain end", 32'(bus.rs_to_alu_ready), 32'd0);
    chk("drain full", 32'(bus.rs_full), 32'd0);

    // Flush with 8 waiting entries and a concurrent ready issue.
    for (int i = 0; i < 8; i++) begin
      drive_issue(OPENUM_SUB, 32'h0, 32'h0, 1'b1, 4'd5, 1'b0, 4'd0, 4'(i), 32'h0, 32'h0);
      tick();
    end
    drive_issue(OPENUM_ADD, 32'h1, 32'h1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7, 32'h0, 32'h0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle_inputs();
    chk("clr ready", 32'(bus.rs_to_alu_ready), 32'd0);
    chk("clr full", 32'(bus.rs_full), 32'd0);
    alu_bcast(4'd5, 32'h55);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("clr quiet%0d", i), 32'(bus.rs_to_alu_ready), 32'd0);
    end

    // Stall with a dispatch pending.
    drive_issue(OPENUM_XOR, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4, 32'h0, 32'h0);
    tick();
    drive_issue(OPENUM_OR, 32'h33, 32'h44, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6, 32'h0, 32'h0);
    tick();
    idle_inputs();
    chk("stall pre ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("stall pre rob", 32'(bus.rs_to_alu_rob_index), 32'd4);
    rdy = 1'b0;
    drive_issue(OPENUM_ADD, 32'h77, 32'h77, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d ready", i), 32'(bus.rs_to_alu_ready), 32'd1);
      chk($sformatf("stall%0d rob", i), 32'(bus.rs_to_alu_rob_index), 32'd4);
      chk($sformatf("stall%0d rs1", i), bus.rs_to_alu_rs1, 32'h11);
    end
    idle_inputs();
    rdy = 1'b1;
    tick();
    chk("resume ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("resume rob", 32'(bus.rs_to_alu_rob_index), 32'd6);
    chk("resume rs1", bus.rs_to_alu_rs1, 32'h33);
    tick();
    chk("resume done", 32'(bus.rs_to_alu_ready), 32'd0);

    // Asynchronous reset while a dispatch is on the outputs.
    drive_issue(OPENUM_ADD, 32'hAB, 32'hCD, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 32'h0, 32'h0);
    tick();
    idle_inputs();
    tick();
    chk("prereset ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("prereset rs1", bus.rs_to_alu_rs1, 32'hAB);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ready", 32'(bus.rs_to_alu_ready), 32'd0);
    chk("async rst rs1", bus.rs_to_alu_rs1, 32'd0);
    chk("async rst rob", 32'(bus.rs_to_alu_rob_index), 32'd0);
    chk("async rst full", 32'(bus.rs_full), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post rst ready", 32'(bus.rs_to_alu_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
